perf_latency_monitor: RTL and testbench
=======================================

Name: perf_latency_monitor

Overview:
Multi-channel, parametrised bus latency monitor. It passively snoops NUM_CH independent valid/ready channel pairs. For each pair it measures the cycles from input-side acceptance to output-side completion, in order. Per-channel count, sum, min, max and last latency are kept and exposed through a channel-select read port for the register-file glue. Sits beside the interconnect; it never drives bus handshakes.

Parameters:
NUM_CH, 2, number of monitored channels (>=1)
CNT_WIDTH, 32, width of timestamp counter, latency values and transaction count
ACC_WIDTH, 48, width of per-channel latency sum (>= CNT_WIDTH)
DEPTH, 16, timestamp FIFO depth per channel (max outstanding transactions, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  measurement enable
clear_i  in  1  synchronous clear of stats, FIFOs and error flags
inp_valid_i  in  NUM_CH  input-side valid per channel
inp_ready_i  in  NUM_CH  input-side ready per channel
oup_valid_i  in  NUM_CH  output-side valid per channel
oup_ready_i  in  NUM_CH  output-side ready per channel
rd_ch_i  in  $clog2(NUM_CH) (min 1)  channel select for stat outputs
stat_count_o  out  CNT_WIDTH  completed transactions, selected channel
stat_sum_o  out  ACC_WIDTH  sum of latencies, selected channel
stat_min_o  out  CNT_WIDTH  minimum latency, selected channel
stat_max_o  out  CNT_WIDTH  maximum latency, selected channel
stat_last_o  out  CNT_WIDTH  most recent latency, selected channel
outstanding_o  out  $clog2(DEPTH+1)  FIFO fill, selected channel
err_overflow_o  out  NUM_CH  sticky: input handshake dropped, FIFO full
err_underflow_o  out  NUM_CH  sticky: output handshake with no outstanding entry

Behaviour:
- Reset: timestamp counter 0; all FIFOs empty; count, sum, last and max 0; min all-ones; error flags 0.
- Timestamp counter: free-running, +1 per cycle, wraps mod 2^CNT_WIDTH. Not affected by clear_i or enable_i.
- Input event on ch c: inp_valid_i[c] && inp_ready_i[c] && enable_i. Pushes the current timestamp into FIFO c.
- Output event on ch c: oup_valid_i[c] && oup_ready_i[c]. It pops only on the actual handshake. A stalled valid (ready low) pops nothing, however long it is held.
- Latency = (timestamp_now - popped_timestamp) mod 2^CNT_WIDTH. Accept at cycle a and complete at cycle b gives latency b-a. Latencies >= 2^CNT_WIDTH alias; this is documented, not flagged.
- Stat update is registered and visible on outputs the cycle after the output event:
  - count += 1, saturating at all-ones
  - sum += latency, saturating at all-ones
  - min = min(min, latency); max = max(max, latency); last = latency
- Simultaneous input and output event, same channel:
  - FIFO non-empty: pop head and push new timestamp in the same cycle; fill unchanged.
  - FIFO empty: pass-through, latency 0 recorded, no push, no error.
- FIFO full plus input event with no same-cycle pop: timestamp dropped, err_overflow_o[c] set. FIFO full with simultaneous pop accepts the push.
- FIFO empty plus output event without same-cycle input event:
  - enable_i=1: err_underflow_o[c] set, stats unchanged.
  - enable_i=0: silently ignored.
- enable_i=0: input events ignored. Output events still drain outstanding entries and update stats, so in-flight transactions complete cleanly.
- clear_i=1: next cycle all FIFOs empty, stats and errors at reset values. clear_i overrides any event in the same cycle (that event is discarded).
- Channels are fully independent; events on different channels in the same cycle are all processed.
- Stat outputs are combinational muxes of registered state by rd_ch_i. rd_ch_i >= NUM_CH returns channel 0.
- Async reset mid-operation: all state returns to reset values immediately; in-flight transactions are lost, with no error flagged.

Test Plan:
- Single transaction: ch0 input handshake at cycle 10, output valid at 13 with ready low until 15 (handshake at 15) -> cycle 16: count=1, last=min=max=5, sum=5.
- Pipelined in-order: ch1 accepts at cycles 0,1,2 and completes at 4,6,9 -> count=3, min=4, max=7, sum=16, outstanding=0.
- Overflow: DEPTH=16, 17 input handshakes on ch0 with no outputs -> err_overflow_o[0]=1, outstanding=16, ch1 flags 0.
- Underflow and pass-through: output handshake on empty ch1 -> err_underflow_o[1]=1. Simultaneous input+output on empty ch0 -> last=0, count+1, no error.
- Wrap and saturation: CNT_WIDTH=4, accept at counter 14, complete at counter 3 -> latency 5. ACC_WIDTH=4 with latencies 9,9 -> sum=15 (saturated).
- Control: clear_i asserted in the same cycle as an output event -> event discarded, min=all-ones next cycle. enable_i=0 with 2 outstanding -> both still measured, new inputs ignored.

Source files
------------

// File: rtl/perf_latency_monitor.sv
// Passive per-channel valid/ready latency monitor: timestamps accepted requests in a
// per-channel FIFO and folds completion latencies into saturating count/sum/min/max/last stats.
module perf_latency_monitor #(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 32,
    parameter int ACC_WIDTH = 48,
    parameter int DEPTH     = 16,
    localparam int RD_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int FILL_W   = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [NUM_CH-1:0]    inp_valid_i,
    input  logic [NUM_CH-1:0]    inp_ready_i,
    input  logic [NUM_CH-1:0]    oup_valid_i,
    input  logic [NUM_CH-1:0]    oup_ready_i,
    input  logic [RD_W-1:0]      rd_ch_i,
    output logic [CNT_WIDTH-1:0] stat_count_o,
    output logic [ACC_WIDTH-1:0] stat_sum_o,
    output logic [CNT_WIDTH-1:0] stat_min_o,
    output logic [CNT_WIDTH-1:0] stat_max_o,
    output logic [CNT_WIDTH-1:0] stat_last_o,
    output logic [FILL_W-1:0]    outstanding_o,
    output logic [NUM_CH-1:0]    err_overflow_o,
    output logic [NUM_CH-1:0]    err_underflow_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ACC_EXT = ACC_WIDTH + 1;
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONES  = '1;
    localparam logic [ACC_WIDTH-1:0] ACC_ONES  = '1;

    logic [CNT_WIDTH-1:0] ts_q, ts_d;
    logic [CNT_WIDTH-1:0] fifo_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_CH];
    logic [FILL_W-1:0]    fill_q   [NUM_CH];
    logic [FILL_W-1:0]    fill_d   [NUM_CH];
    logic [CNT_WIDTH-1:0] count_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] count_d  [NUM_CH];
    logic [ACC_WIDTH-1:0] sum_q    [NUM_CH];
    logic [ACC_WIDTH-1:0] sum_d    [NUM_CH];
    logic [CNT_WIDTH-1:0] min_q    [NUM_CH];
    logic [CNT_WIDTH-1:0] min_d    [NUM_CH];
    logic [CNT_WIDTH-1:0] max_q    [NUM_CH];
    logic [CNT_WIDTH-1:0] max_d    [NUM_CH];
    logic [CNT_WIDTH-1:0] last_q   [NUM_CH];
    logic [CNT_WIDTH-1:0] last_d   [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q, ovf_d;
    logic [NUM_CH-1:0]    unf_q, unf_d;

    logic [NUM_CH-1:0]    inp_ev, oup_ev;
    logic [NUM_CH-1:0]    push, pop, rec;
    logic [CNT_WIDTH-1:0] lat      [NUM_CH];
    logic [ACC_EXT-1:0]   sum_ext  [NUM_CH];
    logic [RD_W-1:0]      sel;

    assign inp_ev = inp_valid_i & inp_ready_i & {NUM_CH{enable_i}};
    assign oup_ev = oup_valid_i & oup_ready_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        ts_d = ts_q + CNT_WIDTH'(1);
        ovf_d = ovf_q;
        unf_d = unf_q;
        push = '0;
        pop = '0;
        rec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            fill_d[c]   = fill_q[c];
            count_d[c]  = count_q[c];
            sum_d[c]    = sum_q[c];
            min_d[c]    = min_q[c];
            max_d[c]    = max_q[c];
            last_d[c]   = last_q[c];
            lat[c]      = ts_q - fifo_q[c][rd_ptr_q[c]];
            sum_ext[c]  = '0;

            // An empty FIFO with a same-cycle accept is a pass-through of zero latency.
            if (oup_ev[c]) begin
                if (fill_q[c] != '0) begin
                    pop[c] = 1'b1;
                    rec[c] = 1'b1;
                    push[c] = inp_ev[c];
                end else if (inp_ev[c]) begin
                    rec[c] = 1'b1;
                    lat[c] = '0;
                end else if (enable_i) begin
                    unf_d[c] = 1'b1;
                end
            end else if (inp_ev[c]) begin
                if (fill_q[c] == FILL_FULL) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    push[c] = 1'b1;
                end
            end

            if (push[c]) wr_ptr_d[c] = ptr_inc(wr_ptr_q[c]);
            if (pop[c])  rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
            if (push[c] && !pop[c]) fill_d[c] = fill_q[c] + FILL_W'(1);
            if (pop[c] && !push[c]) fill_d[c] = fill_q[c] - FILL_W'(1);

            if (rec[c]) begin
                count_d[c] = (count_q[c] == CNT_ONES) ? count_q[c] : count_q[c] + CNT_WIDTH'(1);
                sum_ext[c] = {1'b0, sum_q[c]} + ACC_EXT'(lat[c]);
                sum_d[c]   = sum_ext[c][ACC_WIDTH] ? ACC_ONES : sum_ext[c][ACC_WIDTH-1:0];
                if (lat[c] < min_q[c]) min_d[c] = lat[c];
                if (lat[c] > max_q[c]) max_d[c] = lat[c];
                last_d[c]  = lat[c];
            end

            // Clear wins over anything that happened this cycle.
            if (clear_i) begin
                push[c]     = 1'b0;
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                fill_d[c]   = '0;
                count_d[c]  = '0;
                sum_d[c]    = '0;
                min_d[c]    = CNT_ONES;
                max_d[c]    = '0;
                last_d[c]   = '0;
                ovf_d[c]    = 1'b0;
                unf_d[c]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q  <= '0;
            ovf_q <= '0;
            unf_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                fill_q[c]   <= '0;
                count_q[c]  <= '0;
                sum_q[c]    <= '0;
                min_q[c]    <= CNT_ONES;
                max_q[c]    <= '0;
                last_q[c]   <= '0;
            end
        end else begin
            ts_q  <= ts_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                fill_q[c]   <= fill_d[c];
                count_q[c]  <= count_d[c];
                sum_q[c]    <= sum_d[c];
                min_q[c]    <= min_d[c];
                max_q[c]    <= max_d[c];
                last_q[c]   <= last_d[c];
            end
        end
    end

    // Timestamp storage needs no reset: fill and pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) fifo_q[c][wr_ptr_q[c]] <= ts_q;
        end
    end

    always_comb begin
        sel = rd_ch_i;
        if (int'(rd_ch_i) >= NUM_CH) sel = '0;
    end

    assign stat_count_o    = count_q[sel];
    assign stat_sum_o      = sum_q[sel];
    assign stat_min_o      = min_q[sel];
    assign stat_max_o      = max_q[sel];
    assign stat_last_o     = last_q[sel];
    assign outstanding_o   = fill_q[sel];
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: tb/tb_perf_latency_monitor.sv
// Directed self-checking bench: a default-sized monitor checked against a scoreboard model,
// plus a narrow (4-bit) instance for counter wrap and sum saturation.
module tb_perf_latency_monitor;

    localparam int NCH = 2;
    localparam int DP  = 16;
    localparam longint CNT_ONES = 64'hFFFF_FFFF;
    localparam longint SUM_ONES = 64'hFFFF_FFFF_FFFF;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            enable_i, clear_i;
    logic [NCH-1:0]  inp_valid_i, inp_ready_i, oup_valid_i, oup_ready_i;
    logic [0:0]      rd_ch_i;
    logic [31:0]     stat_count_o, stat_min_o, stat_max_o, stat_last_o;
    logic [47:0]     stat_sum_o;
    logic [4:0]      outstanding_o;
    logic [NCH-1:0]  err_overflow_o, err_underflow_o;

    logic            s_enable, s_clear;
    logic [0:0]      s_iv, s_ir, s_ov, s_or, s_rd;
    logic [3:0]      s_count, s_sum, s_min, s_max, s_last;
    logic [1:0]      s_out;
    logic [0:0]      s_ovf, s_unf;

    perf_latency_monitor #(.NUM_CH(2), .CNT_WIDTH(32), .ACC_WIDTH(48), .DEPTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .clear_i(clear_i),
        .inp_valid_i(inp_valid_i), .inp_ready_i(inp_ready_i),
        .oup_valid_i(oup_valid_i), .oup_ready_i(oup_ready_i), .rd_ch_i(rd_ch_i),
        .stat_count_o(stat_count_o), .stat_sum_o(stat_sum_o), .stat_min_o(stat_min_o),
        .stat_max_o(stat_max_o), .stat_last_o(stat_last_o), .outstanding_o(outstanding_o),
        .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o)
    );

    perf_latency_monitor #(.NUM_CH(1), .CNT_WIDTH(4), .ACC_WIDTH(4), .DEPTH(2)) dut_small (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(s_enable), .clear_i(s_clear),
        .inp_valid_i(s_iv), .inp_ready_i(s_ir), .oup_valid_i(s_ov), .oup_ready_i(s_or),
        .rd_ch_i(s_rd), .stat_count_o(s_count), .stat_sum_o(s_sum), .stat_min_o(s_min),
        .stat_max_o(s_max), .stat_last_o(s_last), .outstanding_o(s_out),
        .err_overflow_o(s_ovf), .err_underflow_o(s_unf)
    );

    // Bench timebase: number of clock edges since reset release.
    longint cyc;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct { int ch; longint lat; } exp_t;
    exp_t   exp_q[$];
    longint acc0[$];
    longint acc1[$];
    longint m_cnt[NCH], m_sum[NCH], m_min[NCH], m_max[NCH], m_last[NCH];
    logic [NCH-1:0] m_ovf, m_unf;

    function automatic int accSize(int ch);
        return (ch == 0) ? acc0.size() : acc1.size();
    endfunction

    function automatic void accPush(int ch, longint v);
        if (ch == 0) acc0.push_back(v);
        else         acc1.push_back(v);
    endfunction

    function automatic longint accPop(int ch);
        if (ch == 0) return acc0.pop_front();
        return acc1.pop_front();
    endfunction

    function automatic void modelReset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_sum[c] = 0; m_min[c] = CNT_ONES; m_max[c] = 0; m_last[c] = 0;
        end
        acc0.delete();
        acc1.delete();
        exp_q.delete();
        m_ovf = '0;
        m_unf = '0;
    endfunction

    function automatic void modelRecord(int ch, longint lat);
        exp_t e;
        e.ch = ch;
        e.lat = lat;
        exp_q.push_back(e);
        if (m_cnt[ch] != CNT_ONES) m_cnt[ch]++;
        m_sum[ch] = (m_sum[ch] + lat > SUM_ONES) ? SUM_ONES : m_sum[ch] + lat;
        if (lat < m_min[ch]) m_min[ch] = lat;
        if (lat > m_max[ch]) m_max[ch] = lat;
        m_last[ch] = lat;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock of stimulus on the main instance; expected latencies go to the scoreboard
    // and are compared against stat_last_o once the registered update is visible.
    task automatic applyStimulus(input logic [NCH-1:0] iv, input logic [NCH-1:0] ir,
                                 input logic [NCH-1:0] ov, input logic [NCH-1:0] ordy,
                                 input logic en, input logic clr);
        exp_t e;
        logic ie, oe;
        inp_valid_i = iv; inp_ready_i = ir; oup_valid_i = ov; oup_ready_i = ordy;
        enable_i = en; clear_i = clr;
        if (clr) begin
            modelReset();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                ie = iv[c] & ir[c] & en;
                oe = ov[c] & ordy[c];
                if (oe) begin
                    if (accSize(c) > 0) begin
                        modelRecord(c, cyc - accPop(c));
                        if (ie) accPush(c, cyc);
                    end else if (ie) begin
                        modelRecord(c, 0);
                    end else if (en) begin
                        m_unf[c] = 1'b1;
                    end
                end else if (ie) begin
                    if (accSize(c) == DP) m_ovf[c] = 1'b1;
                    else                  accPush(c, cyc);
                end
            end
        end
        @(posedge clk_i);
        #1;
        inp_valid_i = '0; inp_ready_i = '0; oup_valid_i = '0; oup_ready_i = '0;
        enable_i = 1'b1; clear_i = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_ch_i = 1'(e.ch);
            #1;
            checkOutput($sformatf("last_ch%0d", e.ch), 64'(stat_last_o), 64'(e.lat));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus('0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic checkStats(input int ch);
        rd_ch_i = 1'(ch);
        #1;
        checkOutput($sformatf("count_ch%0d", ch), 64'(stat_count_o), 64'(m_cnt[ch]));
        checkOutput($sformatf("sum_ch%0d", ch), 64'(stat_sum_o), 64'(m_sum[ch]));
        checkOutput($sformatf("min_ch%0d", ch), 64'(stat_min_o), 64'(m_min[ch]));
        checkOutput($sformatf("max_ch%0d", ch), 64'(stat_max_o), 64'(m_max[ch]));
        checkOutput($sformatf("last_stat_ch%0d", ch), 64'(stat_last_o), 64'(m_last[ch]));
        checkOutput($sformatf("outstanding_ch%0d", ch), 64'(outstanding_o), 64'(accSize(ch)));
        checkOutput($sformatf("ovf_ch%0d", ch), 64'(err_overflow_o[ch]), 64'(m_ovf[ch]));
        checkOutput($sformatf("unf_ch%0d", ch), 64'(err_underflow_o[ch]), 64'(m_unf[ch]));
    endtask

    task automatic smallStep(input logic iv, input logic ov, input logic clr);
        s_iv = iv; s_ir = iv; s_ov = ov; s_or = ov; s_clear = clr;
        @(posedge clk_i);
        #1;
        s_iv = 1'b0; s_ir = 1'b0; s_ov = 1'b0; s_or = 1'b0; s_clear = 1'b0;
    endtask

    initial begin
        enable_i = 1'b1; clear_i = 1'b0; rd_ch_i = '0;
        inp_valid_i = '0; inp_ready_i = '0; oup_valid_i = '0; oup_ready_i = '0;
        s_enable = 1'b1; s_clear = 1'b0; s_rd = '0;
        s_iv = 1'b0; s_ir = 1'b0; s_ov = 1'b0; s_or = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checkStats(0);
        checkStats(1);

        // Single transaction with a two-cycle stalled output valid: latency 5.
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        idle(2);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        checkStats(0);
        checkOutput("single_last", 64'(stat_last_o), 64'd5);

        // Pipelined in-order on ch1: latencies 4, 5, 7.
        repeat (3) applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        idle(1);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        idle(1);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        idle(2);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        checkStats(1);
        checkOutput("pipe_sum", 64'(stat_sum_o), 64'd16);

        // Underflow on empty ch1, pass-through on empty ch0.
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0);
        checkStats(1);
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        checkStats(0);

        // Both channels in the same cycles.
        applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        idle(2);
        applyStimulus(2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0);

        // Fill ch0, push+pop while full, then one more accept overflows.
        repeat (DP) applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        checkStats(0);
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0);
        checkStats(0);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        checkStats(0);
        checkStats(1);

        // Clear together with an output event: event discarded.
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1);
        checkStats(0);
        checkStats(1);

        // Disable with two outstanding: both drain, new input ignored, no underflow.
        repeat (2) applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0);
        checkStats(1);

        // Narrow instance: accept at timestamp 14, complete at 3 after wrap.
        for (int i = 0; i < 16 && (cyc % 16) != 14; i++) smallStep(1'b0, 1'b0, 1'b0);
        checkOutput("small_align", 64'(cyc % 16), 64'd14);
        smallStep(1'b1, 1'b0, 1'b0);
        repeat (4) smallStep(1'b0, 1'b0, 1'b0);
        smallStep(1'b0, 1'b1, 1'b0);
        checkOutput("wrap_last", 64'(s_last), 64'd5);
        checkOutput("wrap_count", 64'(s_count), 64'd1);
        smallStep(1'b0, 1'b0, 1'b1);
        checkOutput("small_clear_min", 64'(s_min), 64'd15);
        for (int k = 0; k < 2; k++) begin
            smallStep(1'b1, 1'b0, 1'b0);
            repeat (8) smallStep(1'b0, 1'b0, 1'b0);
            smallStep(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("sat_sum_%0d", k), 64'(s_sum), (k == 0) ? 64'd9 : 64'd15);
        end
        checkOutput("sat_count", 64'(s_count), 64'd2);
        checkOutput("sat_max", 64'(s_max), 64'd9);

        // Asynchronous reset with transactions in flight.
        repeat (2) applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
        checkStats(0);
        #2;
        rst_ni = 1'b0;
        modelReset();
        checkStats(0);
        checkOutput("rst_small_out", 64'(s_out), 64'd0);
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
